// File: rtl/bfm_apb2apb_cdc_bridge_pkg.sv
// Shared types for the APB-to-APB CDC bridge: FSM state encodings and clog2.
package bfm_apb2apb_cdc_bridge_pkg;

  typedef enum logic {
    PM_IDLE,
    PM_WAIT
  } pm_state_e;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_SETUP,
    SC_ACCESS
  } sc_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/bfm_apb2apb_cdc_bridge_sync_bit.sv
// Multi-flop single-bit synchroniser with asynchronous active-low clear.
module bfm_sync_bit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/bfm_apb2apb_cdc_bridge.sv
// APB master-port to APB slave-port bridge crossing PCLK_PM -> PCLK_SC.
// Toggle req/ack handshake; hold and response registers are stable while their toggle crosses.
module bfm_apb2apb_cdc_bridge
  import bfm_apb2apb_cdc_bridge_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned NSEL        = 16,
  parameter int unsigned SEL_LSB     = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 0,
  parameter int unsigned TPD         = 1
) (
  input  logic            PCLK_PM,
  input  logic            PRESETN_PM,
  input  logic            PCLK_SC,
  input  logic            PSEL_PM,
  input  logic            PENABLE_PM,
  input  logic            PWRITE_PM,
  input  logic [AW-1:0]   PADDR_PM,
  input  logic [DW-1:0]   PWDATA_PM,
  input  logic [DW/8-1:0] PSTRB_PM,
  output logic [DW-1:0]   PRDATA_PM,
  output logic            PREADY_PM,
  output logic            PSLVERR_PM,
  output logic [NSEL-1:0] PSEL_SC,
  output logic            PENABLE_SC,
  output logic            PWRITE_SC,
  output logic [AW-1:0]   PADDR_SC,
  output logic [DW-1:0]   PWDATA_SC,
  output logic [DW/8-1:0] PSTRB_SC,
  input  logic [DW-1:0]   PRDATA_SC,
  input  logic            PREADY_SC,
  input  logic            PSLVERR_SC
);

  localparam int unsigned SELW = (NSEL > 1) ? clog2(NSEL) : 1;
  localparam int unsigned SW   = DW / 8;
  localparam int unsigned TW   = (TIMEOUT > 1) ? clog2(TIMEOUT + 1) : 1;

  // The synthesizable view drives *_SC outputs with zero delay; TPD only matters to annotated models.
  if (TPD > 32'd1000000) begin : g_tpd_range
  end

  logic rst_sc_n;
  logic req_sync, ack_sync;

  bfm_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
    .clk_i (PCLK_SC), .rst_ni(PRESETN_PM), .d_i(1'b1),  .q_o(rst_sc_n)
  );

  // ---------------- master-side domain ----------------
  pm_state_e       pm_state_q, pm_state_d;
  logic            en_prev_q;
  logic            req_q, req_d;
  logic            ack_seen_q, ack_seen_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [DW-1:0]   prdata_q, prdata_d;
  logic            hold_ld;
  logic [AW-1:0]   hold_addr_q;
  logic [DW-1:0]   hold_wdata_q;
  logic [SW-1:0]   hold_strb_q;
  logic            hold_write_q;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            ack_q, ack_d;

  bfm_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk_i (PCLK_PM), .rst_ni(PRESETN_PM), .d_i(ack_q), .q_o(ack_sync)
  );

  always_comb begin
    pm_state_d = pm_state_q;
    req_d      = req_q;
    ack_seen_d = ack_seen_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = prdata_q;
    hold_ld    = 1'b0;
    case (pm_state_q)
      PM_IDLE: begin
        if (PSEL_PM && PENABLE_PM && !en_prev_q) begin
          hold_ld    = 1'b1;
          req_d      = ~req_q;
          pm_state_d = PM_WAIT;
        end
      end
      PM_WAIT: begin
        if (ack_sync != ack_seen_q) begin
          ack_seen_d = ack_sync;
          pready_d   = 1'b1;
          prdata_d   = rsp_rdata_q;
          pslverr_d  = rsp_err_q;
          pm_state_d = PM_IDLE;
        end
      end
      default: pm_state_d = PM_IDLE;
    endcase
  end

  always_ff @(posedge PCLK_PM or negedge PRESETN_PM) begin
    if (!PRESETN_PM) begin
      pm_state_q   <= PM_IDLE;
      en_prev_q    <= 1'b0;
      req_q        <= 1'b0;
      ack_seen_q   <= 1'b0;
      pready_q     <= 1'b0;
      pslverr_q    <= 1'b0;
      prdata_q     <= '0;
      hold_addr_q  <= '0;
      hold_wdata_q <= '0;
      hold_strb_q  <= '0;
      hold_write_q <= 1'b0;
    end else begin
      pm_state_q <= pm_state_d;
      en_prev_q  <= PENABLE_PM;
      req_q      <= req_d;
      ack_seen_q <= ack_seen_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      if (hold_ld) begin
        hold_addr_q  <= PADDR_PM;
        hold_wdata_q <= PWDATA_PM;
        hold_strb_q  <= PSTRB_PM;
        hold_write_q <= PWRITE_PM;
      end
    end
  end

  assign PREADY_PM  = pready_q;
  assign PSLVERR_PM = pslverr_q;
  assign PRDATA_PM  = prdata_q;

  // ---------------- slave-side domain ----------------
  sc_state_e       sc_state_q, sc_state_d;
  logic            req_seen_q, req_seen_d;
  logic            cap_ld;
  logic [AW-1:0]   cap_addr_q;
  logic [DW-1:0]   cap_wdata_q;
  logic [SW-1:0]   cap_strb_q;
  logic            cap_write_q;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [SELW-1:0] hold_idx, cap_idx;
  logic            sc_busy;

  bfm_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk_i (PCLK_SC), .rst_ni(rst_sc_n), .d_i(req_q), .q_o(req_sync)
  );

  assign hold_idx = hold_addr_q[SEL_LSB +: SELW];
  assign cap_idx  = cap_addr_q[SEL_LSB +: SELW];

  always_comb begin
    sc_state_d = sc_state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    cap_ld     = 1'b0;
    case (sc_state_q)
      SC_IDLE: begin
        if (req_sync != req_seen_q) begin
          req_seen_d = req_sync;
          cap_ld     = 1'b1;
          if (32'(hold_idx) < NSEL) begin
            sc_state_d = SC_SETUP;
          end else begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            ack_d       = ~ack_q;
          end
        end
      end
      SC_SETUP: begin
        cnt_d      = '0;
        sc_state_d = SC_ACCESS;
      end
      SC_ACCESS: begin
        if (PREADY_SC) begin
          rsp_rdata_d = PRDATA_SC;
          rsp_err_d   = PSLVERR_SC;
          ack_d       = ~ack_q;
          sc_state_d  = SC_IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == TW'(TIMEOUT - 1))) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          ack_d       = ~ack_q;
          sc_state_d  = SC_IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: sc_state_d = SC_IDLE;
    endcase
  end

  always_ff @(posedge PCLK_SC or negedge rst_sc_n) begin
    if (!rst_sc_n) begin
      sc_state_q  <= SC_IDLE;
      req_seen_q  <= 1'b0;
      ack_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
      cap_strb_q  <= '0;
      cap_write_q <= 1'b0;
    end else begin
      sc_state_q  <= sc_state_d;
      req_seen_q  <= req_seen_d;
      ack_q       <= ack_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
      if (cap_ld) begin
        cap_addr_q  <= hold_addr_q;
        cap_wdata_q <= hold_wdata_q;
        cap_strb_q  <= hold_strb_q;
        cap_write_q <= hold_write_q;
      end
    end
  end

  // Bus outputs are gated by state so everything returns to zero once the cycle completes.
  assign sc_busy    = (sc_state_q != SC_IDLE);
  assign PENABLE_SC = (sc_state_q == SC_ACCESS);
  assign PWRITE_SC  = sc_busy & cap_write_q;
  assign PADDR_SC   = sc_busy ? cap_addr_q  : '0;
  assign PWDATA_SC  = sc_busy ? cap_wdata_q : '0;
  assign PSTRB_SC   = sc_busy ? cap_strb_q  : '0;

  always_comb begin
    PSEL_SC = '0;
    for (int unsigned i = 0; i < NSEL; i++)
      PSEL_SC[i] = sc_busy && (cap_idx == SELW'(i));
  end

endmodule

// File: tb/tb_bfm_apb2apb_cdc_bridge.sv
// Self-checking bench for bfm_apb2apb_cdc_bridge: scripted master, reactive slave model, scoreboard.
`timescale 1ns/1ps
module tb_bfm_apb2apb_cdc_bridge;

  localparam int NS = 12;

  logic          PCLK_PM, PRESETN_PM, PCLK_SC;
  logic          PSEL_PM, PENABLE_PM, PWRITE_PM;
  logic [31:0]   PADDR_PM, PWDATA_PM;
  logic [3:0]    PSTRB_PM;
  logic [31:0]   PRDATA_PM;
  logic          PREADY_PM, PSLVERR_PM;
  logic [NS-1:0] PSEL_SC;
  logic          PENABLE_SC, PWRITE_SC;
  logic [31:0]   PADDR_SC, PWDATA_SC;
  logic [3:0]    PSTRB_SC;
  logic [31:0]   PRDATA_SC;
  logic          PREADY_SC, PSLVERR_SC;

  bfm_apb2apb_cdc_bridge #(.NSEL(NS), .TIMEOUT(16)) dut (
    .PCLK_PM(PCLK_PM), .PRESETN_PM(PRESETN_PM), .PCLK_SC(PCLK_SC),
    .PSEL_PM(PSEL_PM), .PENABLE_PM(PENABLE_PM), .PWRITE_PM(PWRITE_PM),
    .PADDR_PM(PADDR_PM), .PWDATA_PM(PWDATA_PM), .PSTRB_PM(PSTRB_PM),
    .PRDATA_PM(PRDATA_PM), .PREADY_PM(PREADY_PM), .PSLVERR_PM(PSLVERR_PM),
    .PSEL_SC(PSEL_SC), .PENABLE_SC(PENABLE_SC), .PWRITE_SC(PWRITE_SC),
    .PADDR_SC(PADDR_SC), .PWDATA_SC(PWDATA_SC), .PSTRB_SC(PSTRB_SC),
    .PRDATA_SC(PRDATA_SC), .PREADY_SC(PREADY_SC), .PSLVERR_SC(PSLVERR_SC)
  );

  int sc_half = 5;
  initial begin PCLK_PM = 0; forever #5 PCLK_PM = ~PCLK_PM; end
  initial begin PCLK_SC = 0; forever #(sc_half) PCLK_SC = ~PCLK_SC; end

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] rdata; logic err; logic chk_rd; } exp_t;
  exp_t sb_q[$];

  logic [31:0] ref_mem [0:255];
  logic [31:0] slv_mem [0:255];

  // slave model state and observations
  int          ws_cfg = 0;
  int          wcnt = 0;
  int          active_cycles = 0;
  int          acc_cycles = 0;
  logic        setup_seen = 0, acc_after_setup = 0;
  logic [NS-1:0] rec_psel;
  logic [31:0] rec_paddr, rec_pwdata;
  logic [3:0]  rec_pstrb;
  logic        rec_pwrite;

  initial begin
    PREADY_SC = 0; PSLVERR_SC = 0; PRDATA_SC = '0;
    forever begin
      @(negedge PCLK_SC);
      PREADY_SC = 0; PSLVERR_SC = 0; PRDATA_SC = '0;
      if (PSEL_SC != '0) begin
        int sidx;
        logic [7:0] midx;
        active_cycles++;
        checks++;
        if (!$onehot(PSEL_SC)) begin
          errors++;
          $display("FAIL psel_onehot: got %h required one-hot", PSEL_SC);
        end
        sidx = 0;
        for (int i = 0; i < NS; i++) if (PSEL_SC[i]) sidx = i;
        midx = {4'(sidx), PADDR_SC[5:2]};
        if (!PENABLE_SC) begin
          setup_seen = 1; wcnt = 0;
        end else begin
          acc_cycles++;
          if (setup_seen) acc_after_setup = 1;
          rec_psel = PSEL_SC; rec_paddr = PADDR_SC; rec_pwdata = PWDATA_SC;
          rec_pstrb = PSTRB_SC; rec_pwrite = PWRITE_SC;
          if (ws_cfg >= 0 && wcnt == ws_cfg) begin
            PREADY_SC  = 1;
            PSLVERR_SC = (PADDR_SC[5:2] == 4'hF);
            if (PWRITE_SC) begin
              for (int b = 0; b < 4; b++)
                if (PSTRB_SC[b]) slv_mem[midx][8*b +: 8] = PWDATA_SC[8*b +: 8];
            end else begin
              PRDATA_SC = slv_mem[midx];
            end
          end
          wcnt++;
        end
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic force_err,
                          input logic chk_lat, input int exp_lat);
    exp_t e;
    logic [3:0] sel, lo;
    logic [7:0] idx;
    int n;
    logic done;
    sel = addr[27:24]; lo = addr[5:2]; idx = {sel, lo};
    if (force_err || sel >= 4'(NS)) begin
      e.rdata = '0; e.err = 1; e.chk_rd = 1;
    end else begin
      e.err = (lo == 4'hF);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        e.rdata = '0; e.chk_rd = 0;
      end else begin
        e.rdata = ref_mem[idx]; e.chk_rd = 1;
      end
    end
    sb_q.push_back(e);
    @(negedge PCLK_PM);
    PSEL_PM = 1; PENABLE_PM = 0; PWRITE_PM = wr; PADDR_PM = addr; PWDATA_PM = wdata; PSTRB_PM = strb;
    @(negedge PCLK_PM);
    PENABLE_PM = 1;
    @(posedge PCLK_PM);
    n = 0; done = 0;
    while (!done && n < 300) begin
      @(negedge PCLK_PM);
      if (PREADY_PM === 1'b1) done = 1;
      else n++;
    end
    e = sb_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_wait: no PREADY_PM within 300 cycles, addr %h", addr);
      PSEL_PM = 0; PENABLE_PM = 0;
      return;
    end
    if (PSLVERR_PM !== e.err) begin
      errors++;
      $display("FAIL pslverr addr %h: got %b required %b", addr, PSLVERR_PM, e.err);
    end
    if (e.chk_rd) begin
      checks++;
      if (PRDATA_PM !== e.rdata) begin
        errors++;
        $display("FAIL prdata addr %h: got %h required %h", addr, PRDATA_PM, e.rdata);
      end
    end
    if (chk_lat) begin
      checks++;
      if (n + 1 != exp_lat) begin
        errors++;
        $display("FAIL latency addr %h: got %0d edges required %0d", addr, n + 1, exp_lat);
      end
    end
    @(posedge PCLK_PM);
    @(negedge PCLK_PM);
    PSEL_PM = 0; PENABLE_PM = 0;
    checks++;
    if (PREADY_PM !== 1'b0) begin
      errors++;
      $display("FAIL pready_pulse: got %b required 0 one cycle after completion", PREADY_PM);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({PREADY_PM, PSLVERR_PM, PSEL_SC, PENABLE_SC, PWRITE_SC, PADDR_SC, PWDATA_SC, PSTRB_SC} !== '0) begin
      errors++;
      $display("FAIL %s: rdy %b err %b psel %h en %b wr %b addr %h wdata %h strb %h required all 0",
               tag, PREADY_PM, PSLVERR_PM, PSEL_SC, PENABLE_SC, PWRITE_SC, PADDR_SC, PWDATA_SC, PSTRB_SC);
    end
  endtask

  task automatic test_reset();
    PRESETN_PM = 0;
    PSEL_PM = 0; PENABLE_PM = 0; PWRITE_PM = 0; PADDR_PM = '0; PWDATA_PM = '0; PSTRB_PM = '0;
    repeat (4) @(negedge PCLK_PM);
    check_idle_outputs("reset_outputs");
    checks++;
    if (PRDATA_PM !== '0) begin
      errors++;
      $display("FAIL reset_prdata: got %h required 0", PRDATA_PM);
    end
    PRESETN_PM = 1;
    repeat (5) @(negedge PCLK_PM);
  endtask

  task automatic test_write();
    ws_cfg = 0; setup_seen = 0; acc_after_setup = 0;
    apb_xfer(1, 32'h0300_0010, 32'hDEAD_BEEF, 4'hF, 0, 1, 9);
    checks++;
    if (rec_psel !== 12'h008 || acc_after_setup !== 1'b1) begin
      errors++;
      $display("FAIL write_psel: got %h setup-then-access %b required 008 and 1", rec_psel, acc_after_setup);
    end
    checks++;
    if (rec_paddr !== 32'h0300_0010 || rec_pwdata !== 32'hDEAD_BEEF || rec_pstrb !== 4'hF || rec_pwrite !== 1'b1) begin
      errors++;
      $display("FAIL write_bus: addr %h data %h strb %h wr %b required 03000010 deadbeef f 1",
               rec_paddr, rec_pwdata, rec_pstrb, rec_pwrite);
    end
  endtask

  task automatic test_read_wait();
    ref_mem[8'hA1] = 32'h1234_5678;
    slv_mem[8'hA1] = 32'h1234_5678;
    ws_cfg = 3;
    apb_xfer(0, 32'h0A00_0004, '0, '0, 0, 1, 12);
    ws_cfg = 0;
  endtask

  task automatic test_out_of_range();
    int act0;
    act0 = active_cycles;
    apb_xfer(0, 32'h0E00_0000, '0, '0, 0, 0, 0);
    checks++;
    if (active_cycles != act0) begin
      errors++;
      $display("FAIL oor_no_psel: got %0d PSEL_SC cycles required 0", active_cycles - act0);
    end
  endtask

  task automatic test_timeout();
    ws_cfg = -1; acc_cycles = 0;
    apb_xfer(0, 32'h0500_0008, '0, '0, 1, 0, 0);
    checks++;
    if (acc_cycles != 16) begin
      errors++;
      $display("FAIL timeout_access_cycles: got %0d required 16", acc_cycles);
    end
    ws_cfg = 0;
    apb_xfer(1, 32'h0500_0008, 32'hCAFE_F00D, 4'h5, 0, 1, 9);
    apb_xfer(0, 32'h0500_0008, '0, '0, 0, 1, 9);
  endtask

  task automatic test_reset_mid();
    int n;
    ws_cfg = -1;
    @(negedge PCLK_PM);
    PSEL_PM = 1; PENABLE_PM = 0; PWRITE_PM = 1; PADDR_PM = 32'h0200_0020; PWDATA_PM = 32'h5555_AAAA; PSTRB_PM = 4'hF;
    @(negedge PCLK_PM);
    PENABLE_PM = 1;
    n = 0;
    while (PENABLE_SC !== 1'b1 && n < 50) begin
      @(negedge PCLK_SC); n++;
    end
    checks++;
    if (PENABLE_SC !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_access: PENABLE_SC got %b required 1 within 50 cycles", PENABLE_SC);
    end
    repeat (2) @(negedge PCLK_SC);
    #2 PRESETN_PM = 0;
    #1;
    check_idle_outputs("reset_mid_outputs");
    PSEL_PM = 0; PENABLE_PM = 0; ws_cfg = 0;
    repeat (3) @(negedge PCLK_PM);
    PRESETN_PM = 1;
    repeat (5) @(negedge PCLK_PM);
    apb_xfer(0, 32'h0300_0010, '0, '0, 0, 1, 9);
  endtask

  task automatic test_random_slow_sc();
    sc_half = 15;
    repeat (4) @(negedge PCLK_PM);
    for (int k = 0; k < 100; k++) begin
      logic [31:0] a;
      a = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 18'($urandom), 4'($urandom_range(0, 15)), 2'b00};
      ws_cfg = $urandom_range(0, 2);
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0, 0, 0);
    end
    ws_cfg = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 32'hC0DE_0000 + i;
      slv_mem[i] = 32'hC0DE_0000 + i;
    end
    test_reset();
    test_write();
    test_read_wait();
    test_out_of_range();
    test_timeout();
    test_reset_mid();
    test_random_slow_sc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
